pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised ready/valid pipeline stage register. It is the generalised successor to the fixed IF/ID latch and can be dropped between any two CPU pipeline stages. It adds payload-width parametrisation, per-beat valid tracking, backpressure via stall, a synchronous flush that inserts a bubble, and an optional two-entry skid buffer that breaks the combinational ready path. A saturating stall counter feeds the performance/debug view.

## Interface
- `WIDTH`, default 64: payload width in bits; typically instr + pc_plus_4.
- `NOP_VALUE`, default 0: payload presented on `out_data` whenever `out_valid` = 0 (the bubble).
- `SKID`, default 1:
  - 0: single register; `in_ready` is combinational.
  - 1: main + skid register; `in_ready` is registered.
- `CNT_W`, default 16: width of `stall_cnt`.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `startin_n`, input, 1: asynchronous, active-low reset.
- `flush`, input, 1: synchronous flush; highest priority after reset.
- `in_valid`, input, 1: upstream beat present.
- `in_ready`, output, 1: stage can accept a beat this cycle.
- `in_data`, input, WIDTH: upstream payload.
- `out_valid`, output, 1: downstream beat present.
- `out_ready`, input, 1: downstream accepts this cycle.
- `out_data`, output, WIDTH: downstream payload.
- `occupancy`, output, 2: entries held, 0..1 (`SKID`=0) or 0..2 (`SKID`=1).
- `stall_cnt`, output, CNT_W: cycles with `out_valid`=1 and `out_ready`=0, saturating.

## Operation
- Accept occurs on a cycle with `in_valid` & `in_ready`. Deliver occurs on a cycle with `out_valid` & `out_ready`.
- Beats leave in the order accepted. No beat is duplicated or dropped, except by flush.
- `out_valid` = (`occupancy` != 0). `out_data` is the oldest entry, or `NOP_VALUE` when empty.
- SKID=0:
  - `in_ready` = !`out_valid` | `out_ready` (combinational).
  - On accept, the register loads `in_data`.
  - Deliver without accept empties the stage.
- SKID=1: states EMPTY (0), ONE (1), FULL (2). `in_ready` = (state != FULL), derived from flops only.
  - EMPTY: accept -> ONE; main <= `in_data`.
  - ONE, accept and deliver -> ONE; main <= `in_data`.
  - ONE, accept without deliver -> FULL; skid <= `in_data`.
  - ONE, deliver without accept -> EMPTY.
  - FULL, deliver -> ONE; main <= skid. No accept is possible in FULL.
- Flush:
  - Next state is EMPTY / occupancy 0; `out_data` = `NOP_VALUE`.
  - A beat accepted in the flush cycle is discarded. Upstream treats it as consumed.
  - A beat delivered in the flush cycle counts as delivered.
  - `in_ready` keeps its normal value during the flush cycle.
- stall_cnt:
  - +1 on each cycle with `out_valid` & !`out_ready`; holds at 2^CNT_W−1.
  - Not cleared by flush; cleared only by reset.
- Reset (asynchronous assert, any time, including mid-transfer):
  - `occupancy` = 0, `out_valid` = 0, `out_data` = `NOP_VALUE`, `stall_cnt` = 0, skid contents don't-care.
  - `in_ready` = 1 in both modes, since the stage is empty.
  - Release is synchronous to `clk` by the integrating block; the first accept can occur in the first cycle after release.

## Timing
- Latency: a beat accepted at edge N is visible on `out_data` / `out_valid` after edge N, delivered no earlier than edge N+1.
- Throughput: 1 beat/cycle sustained in both modes when `out_ready` = 1.
- SKID=1, `out_ready` low: at most 2 beats absorbed. `in_ready` falls the cycle after the second accept.
- SKID=1: `out_ready` -> `in_ready` has no combinational path. `in_valid` -> `out_valid` has no combinational path in either mode.
- Flush takes effect at the edge it is sampled. `out_valid` = 0 in the following cycle regardless of `in_valid`.
- Simultaneous flush + reset: reset wins.

## Test plan
- Reset values: assert `startin_n`=0 mid-stream with `occupancy`=2 -> immediately `out_valid`=0, `out_data`=`NOP_VALUE`, `in_ready`=1, `stall_cnt`=0.
- Streaming (SKID=1, WIDTH=64): send 0x1..0x10 with `out_ready`=1 -> identical sequence out, one per cycle, first at cycle+1, `occupancy` ≤1, `stall_cnt`=0.
- Backpressure: hold `out_ready`=0 and offer 0xA, 0xB, 0xC -> 0xA, 0xB accepted, `in_ready`=0, `occupancy`=2, 0xC waits. Release -> 0xA, 0xB, 0xC in order, `stall_cnt`=3 after three stalled cycles.
- Flush with accept: `occupancy`=2, pulse `flush` with `in_valid`=1, `in_data`=0xD -> next cycle `out_valid`=0, `out_data`=0, 0xD never appears, `stall_cnt` unchanged.
- SKID=0: `out_ready`=0 with a held beat -> `in_ready`=0 same cycle. `out_ready`=1 -> `in_ready`=1 same cycle with back-to-back transfer.
- Saturation (CNT_W=4): 20 stalled cycles -> `stall_cnt`=15 held. Flush -> still 15. Reset -> 0.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - parametrised ready/valid pipeline stage with optional skid entry
//
// Purpose: register stage placed between two pipeline stages. Holds up to one
// (SKID=0) or two (SKID=1) beats, supports backpressure, a synchronous flush
// that inserts a bubble, and a saturating stall counter.
//
// Ports:
//   clk        rising-edge clock
//   startin_n  asynchronous active-low reset
//   flush      synchronous flush; empties the stage
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat this cycle
//   in_data    upstream payload
//   out_valid  downstream beat present
//   out_ready  downstream accepts this cycle
//   out_data   oldest held payload, NOP_VALUE when empty
//   occupancy  number of held entries
//   stall_cnt  saturating count of cycles with out_valid & !out_ready

module pipe_stage_buf #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               SKID      = 1,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             startin_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic accept;
  logic deliver;

  // With a skid entry, ready depends only on the occupancy flop, which cuts
  // the out_ready -> in_ready path. Without it, a held beat can be replaced
  // in the same cycle it leaves.
  assign in_ready  = (SKID != 0) ? (occ_q != FULL)
                                 : ((occ_q == EMPTY) || out_ready);
  assign out_valid = (occ_q != EMPTY);
  assign out_data  = out_valid ? main_q : NOP_VALUE;
  assign occupancy = occ_q;
  assign stall_cnt = stall_cnt_q;

  assign accept  = in_valid  && in_ready;
  assign deliver = out_valid && out_ready;

  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;

    case (occ_q)
      EMPTY: begin
        if (accept) begin
          occ_d  = ONE;
          main_d = in_data;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          main_d = in_data;
        end else if (accept) begin
          // Only reachable with a skid entry; in single-register mode an
          // accept while holding a beat implies a deliver.
          occ_d  = FULL;
          skid_d = in_data;
        end else if (deliver) begin
          occ_d = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          occ_d  = ONE;
          main_d = skid_q;
        end
      end
      default: occ_d = EMPTY;
    endcase

    // Flush overrides any accept; a beat delivered this cycle still left.
    if (flush) begin
      occ_d = EMPTY;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge startin_n) begin
    if (!startin_n) begin
      occ_q       <= EMPTY;
      main_q      <= NOP_VALUE;
      skid_q      <= NOP_VALUE;
      stall_cnt_q <= '0;
    end else begin
      occ_q       <= occ_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed self-checking bench for pipe_stage_buf

module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] in_data;

  // a: SKID=1 default widths; b: SKID=0; c: SKID=1 with a 4-bit stall counter
  logic        a_in_ready, a_out_valid;
  logic [63:0] a_out_data;
  logic [1:0]  a_occ;
  logic [15:0] a_stall;

  logic        b_in_ready, b_out_valid;
  logic [63:0] b_out_data;
  logic [1:0]  b_occ;
  logic [15:0] b_stall;

  logic        c_in_ready, c_out_valid;
  logic [63:0] c_out_data;
  logic [1:0]  c_occ;
  logic [3:0]  c_stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(64), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .startin_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cnt(a_stall)
  );

  pipe_stage_buf #(.WIDTH(64), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .startin_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .stall_cnt(b_stall)
  );

  pipe_stage_buf #(.WIDTH(64), .SKID(1), .CNT_W(4)) dut_c (
    .clk(clk), .startin_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .occupancy(c_occ), .stall_cnt(c_stall)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    #1;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_out_data !== 64'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", a_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", a_in_ready); end
    checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready_skid0 got=%b exp=1", b_in_ready); end
    checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", a_occ); end
    // Fill to occupancy 2 under backpressure, then reset mid-stream.
    in_valid = 1'b1; in_data = 64'h51;
    tick();
    in_data = 64'h52;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL pre_rst_occ got=%0d exp=2", a_occ); end
    checks++; if (a_stall !== 16'd2) begin failures++; $display("FAIL pre_rst_stall got=%0d exp=2", a_stall); end
    rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL async_rst_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_out_data !== 64'h0) begin failures++; $display("FAIL async_rst_out_data got=%h exp=0", a_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL async_rst_in_ready got=%b exp=1", a_in_ready); end
    checks++; if (a_stall !== 16'd0) begin failures++; $display("FAIL async_rst_stall got=%0d exp=0", a_stall); end
    checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL async_rst_occ got=%0d exp=0", a_occ); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_streaming;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      in_valid = (k < 16);
      in_data  = 64'(k + 1);
      #1;
      checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready k=%0d got=%b exp=1", k, a_in_ready); end
      if (k == 0) begin
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL stream_first_valid got=%b exp=0", a_out_valid); end
      end else begin
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 64'(k)) begin
          failures++; $display("FAIL stream_data k=%0d got=%b/%h exp=1/%h", k, a_out_valid, a_out_data, 64'(k));
        end
        checks++; if (a_occ !== 2'd1) begin failures++; $display("FAIL stream_occ k=%0d got=%0d exp=1", k, a_occ); end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL stream_end_occ got=%0d exp=0", a_occ); end
    checks++; if (a_stall !== 16'd0) begin failures++; $display("FAIL stream_stall got=%0d exp=0", a_stall); end
  endtask

  task automatic test_backpressure;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hA;
    tick();
    in_data = 64'hB;
    checks++; if (a_out_data !== 64'hA || a_in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_one got=%h/%b exp=a/1", a_out_data, a_in_ready);
    end
    tick();
    in_data = 64'hC;
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", a_in_ready); end
    checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL bp_full_occ got=%0d exp=2", a_occ); end
    tick();
    checks++; if (a_occ !== 2'd2 || a_out_data !== 64'hA) begin
      failures++; $display("FAIL bp_hold got=%0d/%h exp=2/a", a_occ, a_out_data);
    end
    tick();
    checks++; if (a_stall !== 16'd3) begin failures++; $display("FAIL bp_stall got=%0d exp=3", a_stall); end
    out_ready = 1'b1;
    tick();
    checks++; if (a_out_data !== 64'hB || a_in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_second got=%h/%b exp=b/1", a_out_data, a_in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++; if (a_out_data !== 64'hC || a_out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_third got=%h/%b exp=c/1", a_out_data, a_out_valid);
    end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", a_out_valid); end
    checks++; if (a_stall !== 16'd3) begin failures++; $display("FAIL bp_stall_final got=%0d exp=3", a_stall); end
  endtask

  task automatic test_flush;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h1;
    tick();
    in_data = 64'h2;
    tick();
    // Full stage: flush while delivering the head; 0xD is offered but not ready.
    flush = 1'b1; in_data = 64'hD; out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL flush_full_ready got=%b exp=0", a_in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 64'h0) begin
      failures++; $display("FAIL flush_bubble got=%b/%h exp=0/0", a_out_valid, a_out_data);
    end
    checks++; if (a_stall !== 16'd1) begin failures++; $display("FAIL flush_stall got=%0d exp=1", a_stall); end
    in_valid = 1'b1; in_data = 64'h5;
    tick();
    // Holding one beat: the accept of 0xD in the flush cycle must be discarded.
    flush = 1'b1; in_data = 64'hD; out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready_normal got=%b exp=1", a_in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 64'h0) begin
      failures++; $display("FAIL flush_accept_dropped got=%b/%h exp=0/0", a_out_valid, a_out_data);
    end
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
      failures++; $display("FAIL flush_no_reappear got=%b/%0d exp=0/0", a_out_valid, a_occ);
    end
    checks++; if (a_stall !== 16'd1) begin failures++; $display("FAIL flush_stall_kept got=%0d exp=1", a_stall); end
  endtask

  task automatic test_skid0;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h11;
    #1;
    checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL s0_empty_ready got=%b exp=1", b_in_ready); end
    tick();
    in_data = 64'h22;
    #1;
    checks++; if (b_in_ready !== 1'b0 || b_out_data !== 64'h11) begin
      failures++; $display("FAIL s0_blocked got=%b/%h exp=0/11", b_in_ready, b_out_data);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL s0_ready_comb got=%b exp=1", b_in_ready); end
    tick();
    in_data = 64'h33;
    checks++; if (b_out_data !== 64'h22 || b_occ !== 2'd1) begin
      failures++; $display("FAIL s0_b2b_1 got=%h/%0d exp=22/1", b_out_data, b_occ);
    end
    tick();
    in_valid = 1'b0;
    checks++; if (b_out_data !== 64'h33 || b_out_valid !== 1'b1) begin
      failures++; $display("FAIL s0_b2b_2 got=%h/%b exp=33/1", b_out_data, b_out_valid);
    end
    tick();
    checks++; if (b_occ !== 2'd0 || b_out_valid !== 1'b0) begin
      failures++; $display("FAIL s0_empty got=%0d/%b exp=0/0", b_occ, b_out_valid);
    end
  endtask

  task automatic test_saturation;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (c_stall !== 4'd15) begin failures++; $display("FAIL sat_value got=%0d exp=15", c_stall); end
    tick();
    tick();
    checks++; if (c_stall !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", c_stall); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (c_stall !== 4'd15 || c_out_valid !== 1'b0) begin
      failures++; $display("FAIL sat_flush got=%0d/%b exp=15/0", c_stall, c_out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (c_stall !== 4'd0) begin failures++; $display("FAIL sat_reset got=%0d exp=0", c_stall); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_skid0();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
